// File: rtl/packet_former_pkg.sv
// Shared definitions for the packet former.
//   - Arbiter/FIFO sizing constants (BUFF_SIZE) and packet framing defaults.
//   - Channel codes as presented by the arbiter on rdy_cnl.
//   - FSM state encodings of the framing controller.
//   - Helpers: channel-code normalisation and header byte construction.
package packet_former_pkg;

  localparam int         BUFF_SIZE       = 4;
  localparam int         PAYLOAD_LEN_DEF = BUFF_SIZE * 4 - 1;
  localparam logic [7:0] SYNC_BYTE_DEF   = 8'hA5;
  localparam int         SETTLE_CYC_DEF  = 2;

  typedef enum logic [1:0] {
    CH_EMPTY = 2'b00,
    CH_1     = 2'b01,
    CH_2     = 2'b10
  } ch_e;

  typedef enum logic [3:0] {
    S_SETTLE = 4'd0,
    S_LATCH  = 4'd1,
    S_SYNC   = 4'd2,
    S_HDR    = 4'd3,
    S_P_RD   = 4'd4,
    S_P_CAP  = 4'd5,
    S_P_SEND = 4'd6,
    S_CSUM   = 4'd7,
    S_NXT    = 4'd8
  } state_e;

  // Code 11 carries no channel and is framed as an empty packet.
  function automatic ch_e norm_ch(input logic [1:0] code);
    case (code)
      2'b01:   return CH_1;
      2'b10:   return CH_2;
      default: return CH_EMPTY;
    endcase
  endfunction

  function automatic logic [7:0] hdr_byte(input ch_e ch);
    return {6'b0, ch};
  endfunction

endpackage

// File: rtl/packet_former_if.sv
// Byte-wide valid/ready stream toward the line transmitter.
//   tx_data  : framed byte
//   tx_valid : tx_data is valid
//   tx_ready : sink accepts the byte when tx_valid && tx_ready
// master = packet former side, slave = line transmitter side.
interface packet_former_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input  tx_ready);
  modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/pf_fifo_reader.sv
// FIFO read side of the packet former.
//   clk               : system clock
//   ch                : latched channel of the packet in progress
//   rd_en             : issue one read strobe to the selected FIFO
//   cap_en            : capture the selected FIFO's read data into the hold reg
//   clr               : clear the hold reg (start of packet)
//   f1_data, f2_data  : FIFO read data, valid the cycle after the strobe
//   f1_rd, f2_rd      : FIFO read strobes (never both high)
//   cap_byte          : selected FIFO data this cycle (zero for empty packets)
//   hold_data         : byte presented as payload
module pf_fifo_reader
  import packet_former_pkg::*;
(
  input  logic       clk,
  input  ch_e        ch,
  input  logic       rd_en,
  input  logic       cap_en,
  input  logic       clr,
  input  logic [7:0] f1_data,
  input  logic [7:0] f2_data,
  output logic       f1_rd,
  output logic       f2_rd,
  output logic [7:0] cap_byte,
  output logic [7:0] hold_data
);

  logic [7:0] hold_q;
  logic [7:0] hold_d;

  always_comb begin
    f1_rd = rd_en && (ch == CH_1);
    f2_rd = rd_en && (ch == CH_2);

    case (ch)
      CH_1:    cap_byte = f1_data;
      CH_2:    cap_byte = f2_data;
      default: cap_byte = 8'h00;
    endcase

    // Cleared at the start of every packet so empty packets send zeros
    // without ever touching the capture path.
    hold_d = hold_q;
    if (clr) begin
      hold_d = 8'h00;
    end else if (cap_en) begin
      hold_d = cap_byte;
    end
  end

  always_ff @(posedge clk) begin
    hold_q <= hold_d;
  end

  assign hold_data = hold_q;

endmodule

// File: rtl/packet_former.sv
// Packet former: frames one packet per arbiter grant as
//   SYNC_BYTE, header {6'b0, ch}, PAYLOAD_LEN payload bytes, checksum
// where checksum = XOR of header and payload. Pulses next when done.
//   clk, rst          : clock, asynchronous active-high reset
//   rdy_cnl           : arbiter channel code, sampled once per packet
//   next              : one-cycle pulse after the checksum byte is accepted
//   f1_rd, f2_rd      : FIFO read strobes
//   f1_data, f2_data  : FIFO read data
//   tx                : byte stream to the line transmitter (master side)
module packet_former
  import packet_former_pkg::*;
#(
  parameter int         PAYLOAD_LEN = PAYLOAD_LEN_DEF,
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter int         SETTLE_CYC  = SETTLE_CYC_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             rdy_cnl,
  output logic                   next,
  output logic                   f1_rd,
  output logic                   f2_rd,
  input  logic [7:0]             f1_data,
  input  logic [7:0]             f2_data,
  packet_former_if.master        tx
);

  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int CNT_W = $clog2(PAYLOAD_LEN + 1);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(PAYLOAD_LEN);

  state_e           state_q, state_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       csum_q, csum_d;
  ch_e              ch_q, ch_d;

  logic       tx_valid;
  logic [7:0] tx_data;
  logic       accept;
  logic [7:0] cap_byte;
  logic [7:0] hold_data;
  logic [CNT_W-1:0] cnt_inc;

  pf_fifo_reader u_reader (
    .clk       (clk),
    .ch        (ch_q),
    .rd_en     (state_q == S_P_RD),
    .cap_en    (state_q == S_P_CAP),
    .clr       (state_q == S_LATCH),
    .f1_data   (f1_data),
    .f2_data   (f2_data),
    .f1_rd     (f1_rd),
    .f2_rd     (f2_rd),
    .cap_byte  (cap_byte),
    .hold_data (hold_data)
  );

  // Outputs decode straight from the state register, so an asynchronous
  // reset drops tx_valid/next/strobes in the same cycle.
  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    next     = 1'b0;
    case (state_q)
      S_SYNC:   begin tx_valid = 1'b1; tx_data = SYNC_BYTE;       end
      S_HDR:    begin tx_valid = 1'b1; tx_data = hdr_byte(ch_q);  end
      S_P_SEND: begin tx_valid = 1'b1; tx_data = hold_data;       end
      S_CSUM:   begin tx_valid = 1'b1; tx_data = csum_q;          end
      S_NXT:    next = 1'b1;
      default:  ;
    endcase
  end

  assign tx.tx_valid = tx_valid;
  assign tx.tx_data  = tx_data;
  assign accept      = tx_valid && tx.tx_ready;
  assign cnt_inc     = cnt_q + CNT_W'(1);

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    cnt_d    = cnt_q;
    csum_d   = csum_q;
    ch_d     = ch_q;
    case (state_q)
      S_SETTLE: begin
        // Gives the arbiter time to update rdy_cnl after the last next pulse.
        if (settle_q == SETTLE_LAST) begin
          settle_d = '0;
          state_d  = S_LATCH;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      S_LATCH: begin
        ch_d    = norm_ch(rdy_cnl);
        csum_d  = hdr_byte(norm_ch(rdy_cnl));
        cnt_d   = '0;
        state_d = S_SYNC;
      end
      S_SYNC: begin
        if (accept) state_d = S_HDR;
      end
      S_HDR: begin
        if (accept) state_d = (ch_q != CH_EMPTY) ? S_P_RD : S_P_SEND;
      end
      S_P_RD: begin
        state_d = S_P_CAP;
      end
      S_P_CAP: begin
        csum_d  = csum_q ^ cap_byte;
        state_d = S_P_SEND;
      end
      S_P_SEND: begin
        if (accept) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_LAST) begin
            state_d = S_CSUM;
          end else begin
            state_d = (ch_q != CH_EMPTY) ? S_P_RD : S_P_SEND;
          end
        end
      end
      S_CSUM: begin
        if (accept) state_d = S_NXT;
      end
      S_NXT: begin
        state_d = S_SETTLE;
      end
      default: begin
        state_d = S_SETTLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_SETTLE;
      settle_q <= '0;
      cnt_q    <= '0;
      csum_q   <= 8'h00;
      ch_q     <= CH_EMPTY;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      cnt_q    <= cnt_d;
      csum_q   <= csum_d;
      ch_q     <= ch_d;
    end
  end

endmodule

// File: tb/tb_packet_former.sv
module tb_packet_former;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] rdy_cnl;
  logic       next;
  logic       f1_rd, f2_rd;
  logic [7:0] f1_data, f2_data;

  packet_former_if txif ();

  packet_former dut (
    .clk     (clk),
    .rst     (rst),
    .rdy_cnl (rdy_cnl),
    .next    (next),
    .f1_rd   (f1_rd),
    .f2_rd   (f2_rd),
    .f1_data (f1_data),
    .f2_data (f2_data),
    .tx      (txif)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // FIFO models: FIFO 1 repeats 01..0F, FIFO 2 always FF; data one cycle after strobe.
  int p1;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      p1 <= 0;
    end else begin
      if (f1_rd) begin
        f1_data <= 8'((p1 % 15) + 1);
        p1 <= p1 + 1;
      end
      if (f2_rd) f2_data <= 8'hFF;
    end
  end

  // Stream monitor, sampled on the falling edge.
  logic [7:0] rx_q[$];
  int         next_cyc[$];
  int         f1_cnt = 0, f2_cnt = 0, next_cnt = 0;
  int         stall_err = 0, both_err = 0, next_err = 0;
  logic       prev_stall = 1'b0, prev_next = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      prev_next  = 1'b0;
    end else begin
      if (prev_stall && !(txif.tx_valid && txif.tx_data === prev_data)) stall_err++;
      if (txif.tx_valid && txif.tx_ready) rx_q.push_back(txif.tx_data);
      prev_stall = txif.tx_valid && !txif.tx_ready;
      prev_data  = txif.tx_data;
      if (f1_rd) f1_cnt++;
      if (f2_rd) f2_cnt++;
      if (f1_rd && f2_rd) both_err++;
      if (next) begin
        next_cnt++;
        next_cyc.push_back(cyc);
        if (prev_next) next_err++;
      end
      prev_next = next;
    end
  end

  int n_assert = 0;
  int n_fail   = 0;
  logic rand_rdy = 1'b0;
  logic [7:0] exp_pkt [18];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int nc(input int i);
    if (i >= 0 && i < next_cyc.size()) return next_cyc[i];
    return -100000;
  endfunction

  function automatic logic [7:0] rxb(input int i);
    if (i < rx_q.size()) return rx_q[i];
    return 8'hxx;
  endfunction

  task automatic wait_next(input int target, input int budget);
    int k = 0;
    while (next_cnt < target && k < budget) begin
      @(posedge clk); #1;
      if (rand_rdy) txif.tx_ready = 1'($urandom_range(0, 1));
      k++;
    end
    chk("wait_next", 32'(next_cnt), 32'(target));
  endtask

  task automatic set_data_pkt(input logic [7:0] hdr, input logic [7:0] csum);
    exp_pkt[0] = 8'hA5;
    exp_pkt[1] = hdr;
    for (int i = 0; i < 15; i++) exp_pkt[2+i] = 8'(i + 1);
    exp_pkt[17] = csum;
  endtask

  task automatic set_const_pkt(input logic [7:0] hdr, input logic [7:0] val, input logic [7:0] csum);
    exp_pkt[0] = 8'hA5;
    exp_pkt[1] = hdr;
    for (int i = 0; i < 15; i++) exp_pkt[2+i] = val;
    exp_pkt[17] = csum;
  endtask

  task automatic check_pkt(input string tag, input int base);
    for (int i = 0; i < 18; i++) chk($sformatf("%s_b%0d", tag, i), 32'(rxb(base + i)), 32'(exp_pkt[i]));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_next"},     32'(next),          32'(0));
    chk({tag, "_f1_rd"},    32'(f1_rd),         32'(0));
    chk({tag, "_f2_rd"},    32'(f2_rd),         32'(0));
    chk({tag, "_tx_valid"}, 32'(txif.tx_valid), 32'(0));
    chk({tag, "_tx_data"},  32'(txif.tx_data),  32'(0));
  endtask

  initial begin
    int rel, base, s1, s2, n0;
    rst = 1'b1;
    rdy_cnl = 2'b01;
    txif.tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");

    // Two back-to-back FIFO 1 packets.
    @(posedge clk); #1;
    rst = 1'b0;
    rel = cyc; base = rx_q.size(); s1 = f1_cnt; s2 = f2_cnt;
    wait_next(1, 100);
    chk("first_next_lat", 32'(nc(0) - rel), 32'(51));
    wait_next(2, 100);
    chk("data_gap", 32'(nc(1) - nc(0)), 32'(52));
    set_data_pkt(8'h01, 8'h01);
    check_pkt("ch1a", base);
    check_pkt("ch1b", base + 18);
    chk("ch1_f1_strobes", 32'(f1_cnt - s1), 32'(30));
    chk("ch1_f2_strobes", 32'(f2_cnt - s2), 32'(0));

    // Empty packets.
    rdy_cnl = 2'b00;
    n0 = next_cnt; base = rx_q.size(); s1 = f1_cnt; s2 = f2_cnt;
    wait_next(n0 + 2, 100);
    chk("empty_gap0", 32'(nc(n0) - nc(n0 - 1)), 32'(22));
    chk("empty_gap1", 32'(nc(n0 + 1) - nc(n0)), 32'(22));
    set_const_pkt(8'h00, 8'h00, 8'h00);
    check_pkt("empty", base);
    chk("empty_strobes", 32'((f1_cnt - s1) + (f2_cnt - s2)), 32'(0));

    // FIFO 2 packet.
    rdy_cnl = 2'b10;
    n0 = next_cnt; base = rx_q.size(); s1 = f1_cnt; s2 = f2_cnt;
    wait_next(n0 + 1, 100);
    set_const_pkt(8'h02, 8'hFF, 8'hFD);
    check_pkt("ch2", base);
    chk("ch2_f1_strobes", 32'(f1_cnt - s1), 32'(0));
    chk("ch2_f2_strobes", 32'(f2_cnt - s2), 32'(15));

    // FIFO 1 packet under random backpressure.
    rdy_cnl = 2'b01;
    n0 = next_cnt; base = rx_q.size(); s1 = f1_cnt;
    rand_rdy = 1'b1;
    wait_next(n0 + 1, 600);
    rand_rdy = 1'b0;
    txif.tx_ready = 1'b1;
    set_data_pkt(8'h01, 8'h01);
    check_pkt("bp", base);
    chk("bp_f1_strobes", 32'(f1_cnt - s1), 32'(15));
    chk("bp_stall_stable", 32'(stall_err), 32'(0));

    // rdy_cnl changes mid-payload; header keeps the latched channel.
    n0 = next_cnt; base = rx_q.size(); s1 = f1_cnt; s2 = f2_cnt;
    repeat (12) @(posedge clk);
    #1;
    rdy_cnl = 2'b10;
    wait_next(n0 + 1, 100);
    check_pkt("midchg", base);
    chk("midchg_f1_strobes", 32'(f1_cnt - s1), 32'(15));
    chk("midchg_f2_strobes", 32'(f2_cnt - s2), 32'(0));

    // Code 11 frames as an empty packet.
    rdy_cnl = 2'b11;
    n0 = next_cnt; base = rx_q.size(); s1 = f1_cnt; s2 = f2_cnt;
    wait_next(n0 + 1, 100);
    set_const_pkt(8'h00, 8'h00, 8'h00);
    check_pkt("code11", base);
    chk("code11_strobes", 32'((f1_cnt - s1) + (f2_cnt - s2)), 32'(0));

    // Reset in the middle of a payload.
    rdy_cnl = 2'b01;
    n0 = next_cnt;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_no_next", 32'(next_cnt), 32'(n0));
    rst = 1'b0;
    rel = cyc; base = rx_q.size(); s1 = f1_cnt;
    wait_next(n0 + 1, 100);
    chk("midrst_next_lat", 32'(nc(n0) - rel), 32'(51));
    set_data_pkt(8'h01, 8'h01);
    check_pkt("postrst", base);
    chk("postrst_f1_strobes", 32'(f1_cnt - s1), 32'(15));

    chk("both_strobes", 32'(both_err), 32'(0));
    chk("next_one_cycle", 32'(next_err), 32'(0));
    chk("stall_stable", 32'(stall_err), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/packet_former.md
# packet_former

Downstream stage of the channel arbiter (`block_control`). Consumes the arbiter's channel code `rdy_cnl`, drains one packet's worth of bytes from the selected input FIFO (or synthesises an empty packet), and frames them as sync + header + payload + checksum on a byte-wide valid/ready stream toward the line transmitter. Pulses `next` when the packet is fully sent, which releases the arbiter to pick the next channel.

## Interface
- `PAYLOAD_LEN`, default `` `BUFF_SIZE*4-1 `` (15 for `BUFF_SIZE`=4): payload bytes per packet; equals the arbiter's FIFO readiness threshold.
- `SYNC_BYTE`, default 8'hA5: first byte of every packet.
- `SETTLE_CYC`, default 2: cycles waited before sampling `rdy_cnl`.

- `clk`  in  1  system clock; all logic on posedge.
- `rst`  in  1  reset, asynchronous, active-high.
- `rdy_cnl`  in  2  arbiter code: 00 empty packet, 01 FIFO 1, 10 FIFO 2, 11 treated as 00.
- `next`  out  1  one-cycle pulse: packet finished, arbiter may advance.
- `f1_rd`, `f2_rd`  out  1  read strobes to FIFO 1 / FIFO 2; one byte per strobe.
- `f1_data`, `f2_data`  in  8  FIFO read data, valid the cycle after the strobe.
- `tx_data`  out  8  framed byte.
- `tx_valid`  out  1  `tx_data` valid.
- `tx_ready`  in  1  sink accepts byte when `tx_valid && tx_ready`.

## Operation
- Packet: `SYNC_BYTE`, header {6'b0, ch}, `PAYLOAD_LEN` payload bytes, checksum = XOR of header and all payload bytes (sync excluded). Total `PAYLOAD_LEN`+3 bytes.
- Empty packet (ch=00): payload all 8'h00, no FIFO strobes.
- FSM states and transitions:
  - SETTLE: counts `SETTLE_CYC` cycles, -> LATCH. Covers the arbiter's 2-cycle update latency after `next`.
  - LATCH: ch_r <= `rdy_cnl` (11 -> 00); csum <= {6'b0, ch}; byte count <= 0; -> SYNC.
  - SYNC: present `SYNC_BYTE`; on accept -> HDR.
  - HDR: present header; on accept -> P_RD if ch_r≠0, else P_SEND with data 00.
  - P_RD: assert selected `fN_rd` one cycle -> P_CAP.
  - P_CAP: capture selected `fN_data` into hold reg; csum ^= byte -> P_SEND.
  - P_SEND: present hold reg; on accept count+1; if count==`PAYLOAD_LEN` -> CSUM, else P_RD (data) / P_SEND with 00 (empty).
  - CSUM: present csum; on accept -> NXT.
  - NXT: `next`=1 for this cycle only -> SETTLE.
- `tx_data` stable while `tx_valid && !tx_ready`; `tx_valid` never drops without acceptance.
- At most one `fN_rd` high per cycle; never both; never while in a state other than P_RD.
- `rdy_cnl` ignored outside LATCH. FIFO underflow not checked: arbiter guarantees ≥`PAYLOAD_LEN` bytes.

## Timing
- Reset values: `next`=0, `f1_rd`=`f2_rd`=0, `tx_valid`=0, `tx_data`=8'h00; state SETTLE, counters 0, csum 0.
- Reset mid-packet: abort immediately, no `next` pulse, partial packet discarded; restart from SETTLE.
- With `tx_ready`=1: data packet SETTLE 2 + LATCH 1 + SYNC 1 + HDR 1 + 3×`PAYLOAD_LEN` + CSUM 1 + NXT 1 = 52 cycles between `next` pulses (len 15); empty packet 22 cycles.
- Backpressure extends only the stalled send state; FIFO strobe count per packet unaffected.
- `next` first asserted ≥ `SETTLE_CYC`+4+`PAYLOAD_LEN` cycles after reset release.

## Structure
- `params.vh`: `BUFF_SIZE` (existing), add `SYNC_BYTE`, `PAYLOAD_LEN`, channel codes CH_EMPTY/CH_1/CH_2, FSM state encodings.
- One natural sub-module: `pf_fifo_reader` (strobe select, one-cycle capture into hold reg, channel mux); checksum and FSM stay in the top.

## Test plan
- Reset then `rdy_cnl`=01, FIFO 1 holds 01..0F, `tx_ready`=1 -> stream A5,01,01..0F,01; 15 `f1_rd` strobes, 0 `f2_rd`; `next` one cycle, 52 cycles apart.
- `rdy_cnl`=00 -> A5,00, fifteen 00, 00; no strobes; `next` every 22 cycles.
- `rdy_cnl`=10, FIFO 2 fifteen FF -> A5,02,FF×15,FD; only `f2_rd` strobes.
- `tx_ready` toggling 1/0 pseudo-randomly, ch 01 -> identical byte sequence, `tx_data` stable during every stall, exactly 15 strobes.
- `rdy_cnl` changes during payload / set to 11 at LATCH -> header uses latched value; 11 yields empty packet header 00.
- `rst` asserted mid-payload -> outputs to reset values same cycle, no `next`; after release full fresh packet starting A5.
